ysyx_24100005_dmem_slave: RTL and testbench

YSYX_24100005_DMEM_SLAVE -- requirements
Module: ysyx_24100005_dmem_slave

---
 rtl/ysyx_24100005_dmem_slave.sv | 120 ++++++++++++
 tb/tb_ysyx_24100005_dmem_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_dmem_slave.sv
// Word-addressed data memory slave with a valid/ready request and response channel.
// One transaction in flight; the response appears a fixed LATENCY cycles after acceptance.
module ysyx_24100005_dmem_slave #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam logic [32:0] LIMIT = 33'(BASE) + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept_c, fire_c;
  logic            wen_q;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      wmask_q;
  logic [31:0]     offset_c;
  logic [AW-1:0]   idx_c;
  logic            ok_c;
  logic [31:0]     mem [DEPTH];

  // Upper mask lanes carry no meaning for a 32-bit word.
  logic unused_wmask_hi;
  assign unused_wmask_hi = ^req_wmask[7:4];

  // Window and alignment check on the latched address; 33-bit compare prevents wrap.
  always_comb begin
    offset_c = addr_q - BASE;
    idx_c    = AW'(offset_c >> 2);
    ok_c     = ({1'b0, addr_q} >= {1'b0, BASE}) && ({1'b0, addr_q} < LIMIT) &&
               (addr_q[1:0] == 2'b00);
  end

  // Next-state and latency counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    fire_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = WAIT;
          cnt_d    = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          fire_c  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latches and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      if (accept_c) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask[3:0];
      end
      if (fire_c) begin
        rsp_err   <= !ok_c;
        rsp_rdata <= (ok_c && !wen_q) ? mem[idx_c] : '0;
      end
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (fire_c && wen_q && ok_c) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_dmem_slave.sv
// Bench for the dmem slave: directed vector table, reset-abort sequence, then random traffic
// against an associative-array memory model. A LATENCY=1 instance runs in lock-step.
module tb_ysyx_24100005_dmem_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned AW    = 10;
  localparam longint      WSPAN = 4 * (longint'(1) << AW);

  logic        clk, rst;
  logic        req_valid, req_wen, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] mdl [int];

  ysyx_24100005_dmem_slave #(.BASE(BASE), .AW(AW), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  ysyx_24100005_dmem_slave #(.BASE(BASE), .AW(AW), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mask;
    int          hold;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    longint ua = longint'(a);
    return (ua < longint'(BASE)) || (ua >= longint'(BASE) + WSPAN) || (a[1:0] != 2'b00);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    logic [31:0] w;
    int k = model_idx(a);
    w = mdl.exists(k) ? mdl[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[k] = w;
  endfunction

  // One full transaction on both instances; a junk store is held on req_* while busy.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] mask, input int hold, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    int cyc, lat1;
    bit stable, busy_ok;
    logic [31:0] r0;
    logic e0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    rsp_ready = 1'b0;
    check({tag, " req_ready idle"}, 32'(req_ready0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_wen = 1'b1; req_addr = BASE; req_wdata = $urandom; req_wmask = 8'hFF;
    cyc = 0; lat1 = -1; busy_ok = 1'b1;
    while (cyc < 20 && !rsp_valid0) begin
      if (rsp_valid1 && lat1 < 0) lat1 = cyc;
      if (req_ready0 || req_ready1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (rsp_valid1 && lat1 < 0) lat1 = cyc;
    check({tag, " latency2"}, 32'(cyc), 32'd2);
    check({tag, " latency1"}, 32'(lat1), 32'd1);
    check({tag, " rdata"}, rsp_rdata0, exp_rdata);
    check({tag, " err"}, 32'(rsp_err0), 32'(exp_err));
    check({tag, " rdata L1"}, rsp_rdata1, exp_rdata);
    check({tag, " err L1"}, 32'(rsp_err1), 32'(exp_err));
    r0 = rsp_rdata0; e0 = rsp_err0; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid0 || rsp_rdata0 !== r0 || rsp_err0 !== e0 || req_ready0) stable = 1'b0;
    end
    if (hold > 0) check({tag, " held stable"}, 32'(stable), 32'd1);
    check({tag, " busy not ready"}, 32'(busy_ok), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid0), 32'd0);
    check({tag, " ready back"}, 32'(req_ready0), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] a, wd, er;
    logic [7:0] mk;
    logic wn;
    bit e;
    int sel, idx;

    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset rsp_valid", 32'(rsp_valid0), 32'd0);
    check("reset rsp_rdata", rsp_rdata0, 32'd0);
    check("reset rsp_err", 32'(rsp_err0), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready0), 32'd1);
    check("post-reset rsp_valid", 32'(rsp_valid0), 32'd0);

    //               wen   addr          wdata         mask  hold rdata         err
    vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         8'h00, 0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0010, 32'h0000_AB00, 8'hF2, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         8'h00, 5, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         8'h00, 0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h8000_1000, 32'h0,         8'h00, 0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h8000_0002, 32'h0,         8'h00, 5, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h8000_0012, 32'h5555_5555, 8'h0F, 0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         8'h00, 0, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 8'h0F, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h8000_1000, 32'h1111_1111, 8'h0F, 0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h8000_0FFC, 32'h0,         8'h00, 0, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0020, 32'hA5A5_5A5A, 8'h0F, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h8000_0020, 32'h0,         8'h00, 0, 32'hA5A5_5A5A, 1'b0});

    foreach (vecs[i]) begin
      txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].hold,
          vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
      if (vecs[i].wen && !vecs[i].err) model_store(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
    end

    // Reset while the store is still waiting: nothing written, response aborted.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 32'h1234_5678; req_wmask = 8'h0F; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort rsp_valid L2", 32'(rsp_valid0), 32'd0);
    check("abort rsp_valid L1", 32'(rsp_valid1), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 32'h8000_0020, 32'h0, 8'h00, 0, 32'hA5A5_5A5A, 1'b0, "after abort");

    // Seed the words used by random traffic so every load has a known value.
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      a  = BASE + 32'(4 * k);
      txn(1'b1, a, wd, 8'h0F, 0, 32'h0, 1'b0, $sformatf("seed%0d", k));
      model_store(a, wd, 8'h0F);
    end

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 7));
      idx = int'($urandom_range(0, 15));
      a = BASE + 32'(4 * idx);
      if (sel == 0)      a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = BASE + 32'h1000 + 32'(4 * idx);
      else if (sel == 2) a = BASE - 32'(4 * (idx + 1));
      wn = 1'($urandom_range(0, 1));
      wd = $urandom;
      mk = 8'($urandom);
      e  = model_err(a);
      er = (e || wn) ? 32'h0 : mdl[model_idx(a)];
      txn(wn, a, wd, mk, int'($urandom_range(0, 2)), er, e, $sformatf("rnd%0d", n));
      if (wn && !e) model_store(a, wd, mk);
    end

    // Final readback of every seeded word against the model.
    for (int k = 0; k < 16; k++) begin
      a = BASE + 32'(4 * k);
      txn(1'b0, a, 32'h0, 8'h00, 0, mdl[k], 1'b0, $sformatf("final%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
